// File: rtl/rsa_xcel_naive_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rsa_xcel_naive_modexp_ctrl
// Brief    : Right-to-left square-and-multiply modular exponentiation
//            controller driving an external multiply-remainder unit.
// Revision : 1.0
// ============================================================================

module rsa_xcel_naive_modexp_ctrl #(
    parameter int nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3*nbits-1:0] istream_msg,
    input  logic               istream_val,
    output logic               istream_rdy,
    output logic [nbits-1:0]   ostream_msg,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [3*nbits-1:0] mr_req_msg,
    output logic               mr_req_val,
    input  logic               mr_req_rdy,
    input  logic [nbits-1:0]   mr_resp_msg,
    input  logic               mr_resp_val,
    output logic               mr_resp_rdy,
    output logic               busy
);

    localparam logic [nbits-1:0] c_one = nbits'(1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_RED_B_REQ  = 4'd1,
        S_RED_B_WAIT = 4'd2,
        S_RED_R_REQ  = 4'd3,
        S_RED_R_WAIT = 4'd4,
        S_CHECK      = 4'd5,
        S_MUL_REQ    = 4'd6,
        S_MUL_WAIT   = 4'd7,
        S_SQR_REQ    = 4'd8,
        S_SQR_WAIT   = 4'd9,
        S_DONE       = 4'd10
    } state_t;

    state_t           r_state;
    logic [nbits-1:0] r_n;
    logic [nbits-1:0] r_e;
    logic [nbits-1:0] r_b;
    logic [nbits-1:0] r_r;
    logic [3*nbits-1:0] w_req_msg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_e     <= '0;
            r_b     <= '0;
            r_r     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (istream_val) begin
                        r_n     <= istream_msg[3*nbits-1:2*nbits];
                        r_e     <= istream_msg[2*nbits-1:nbits];
                        r_b     <= istream_msg[nbits-1:0];
                        r_state <= S_RED_B_REQ;
                    end
                end
                S_RED_B_REQ: if (mr_req_rdy) r_state <= S_RED_B_WAIT;
                S_RED_B_WAIT: begin
                    if (mr_resp_val) begin
                        r_b     <= mr_resp_msg;
                        r_state <= S_RED_R_REQ;
                    end
                end
                S_RED_R_REQ: if (mr_req_rdy) r_state <= S_RED_R_WAIT;
                S_RED_R_WAIT: begin
                    if (mr_resp_val) begin
                        r_r     <= mr_resp_msg;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_e == '0)
                        r_state <= S_DONE;
                    else if (r_e[0])
                        r_state <= S_MUL_REQ;
                    else
                        r_state <= S_SQR_REQ;
                end
                S_MUL_REQ: if (mr_req_rdy) r_state <= S_MUL_WAIT;
                S_MUL_WAIT: begin
                    if (mr_resp_val) begin
                        r_r <= mr_resp_msg;
                        // Last exponent bit consumed: the trailing square is useless.
                        if (r_e[nbits-1:1] == '0) begin
                            r_e     <= r_e >> 1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SQR_REQ;
                        end
                    end
                end
                S_SQR_REQ: if (mr_req_rdy) r_state <= S_SQR_WAIT;
                S_SQR_WAIT: begin
                    if (mr_resp_val) begin
                        r_b     <= mr_resp_msg;
                        r_e     <= r_e >> 1;
                        r_state <= S_CHECK;
                    end
                end
                S_DONE: if (ostream_rdy) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_req_msg = '0;
        case (r_state)
            S_RED_B_REQ: w_req_msg = {r_n, r_b, c_one};
            S_RED_R_REQ: w_req_msg = {r_n, c_one, c_one};
            S_MUL_REQ:   w_req_msg = {r_n, r_r, r_b};
            S_SQR_REQ:   w_req_msg = {r_n, r_b, r_b};
            default:     w_req_msg = '0;
        endcase
    end

    // Reset gating keeps istream_rdy low while IDLE is being forced.
    assign istream_rdy = (r_state == S_IDLE) && reset;
    assign busy        = (r_state != S_IDLE);
    assign ostream_val = (r_state == S_DONE);
    assign ostream_msg = r_r;
    assign mr_req_msg  = w_req_msg;
    assign mr_req_val  = (r_state == S_RED_B_REQ) || (r_state == S_RED_R_REQ) ||
                         (r_state == S_MUL_REQ)   || (r_state == S_SQR_REQ);
    assign mr_resp_rdy = (r_state == S_RED_B_WAIT) || (r_state == S_RED_R_WAIT) ||
                         (r_state == S_MUL_WAIT)   || (r_state == S_SQR_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_rsa_xcel_naive_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_xcel_naive_modexp_ctrl
// Brief    : Self-checking bench with a behavioural multiply-remainder unit
//            and an arithmetic modexp reference.
// Revision : 1.0
// ============================================================================

module tb_rsa_xcel_naive_modexp_ctrl;

    localparam int NB = 32;
    localparam int W  = 3*NB;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  istream_msg;
    logic          istream_val;
    logic          istream_rdy;
    logic [NB-1:0] ostream_msg;
    logic          ostream_val;
    logic          ostream_rdy;
    logic [W-1:0]  mr_req_msg;
    logic          mr_req_val;
    logic          mr_req_rdy;
    logic [NB-1:0] mr_resp_msg;
    logic          mr_resp_val;
    logic          mr_resp_rdy;
    logic          busy;

    rsa_xcel_naive_modexp_ctrl #(.nbits(NB)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_msg (istream_msg),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .ostream_msg (ostream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .mr_req_msg  (mr_req_msg),
        .mr_req_val  (mr_req_val),
        .mr_req_rdy  (mr_req_rdy),
        .mr_resp_msg (mr_resp_msg),
        .mr_resp_val (mr_resp_val),
        .mr_resp_rdy (mr_resp_rdy),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] mulmod(input logic [NB-1:0] n, a, b);
        longint unsigned aa, bb, nn;
        if (n == '0) return '0;
        aa = 64'(a);
        bb = 64'(b);
        nn = 64'(n);
        return NB'((aa * bb) % nn);
    endfunction

    function automatic logic [NB-1:0] ref_modexp(input logic [NB-1:0] b, e, n);
        longint unsigned r, x, nn;
        logic [NB-1:0] ee;
        nn = 64'(n);
        r  = 64'd1 % nn;
        x  = 64'(b) % nn;
        ee = e;
        while (ee != '0) begin
            if (ee[0]) r = (r * x) % nn;
            x  = (x * x) % nn;
            ee = ee >> 1;
        end
        return NB'(r);
    endfunction

    function automatic int ref_txns(input logic [NB-1:0] e);
        int msb;
        msb = 0;
        if (e == '0) return 2;
        for (int i = 0; i < NB; i++) if (e[i]) msb = i;
        return 2 + $countones(e) + msb;
    endfunction

    // Behavioural multiply-remainder unit with programmable stalls
    int req_delay  = 0;
    int resp_delay = 0;
    int mr_st      = 0;
    int mr_cnt     = 0;
    int txn_cnt    = 0;
    logic [NB-1:0] cap_n, cap_a, cap_b;

    initial begin
        mr_req_rdy  = 1'b0;
        mr_resp_val = 1'b0;
        mr_resp_msg = '0;
        cap_n = '0; cap_a = '0; cap_b = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mr_st = 0; mr_cnt = 0;
                mr_req_rdy = 1'b0; mr_resp_val = 1'b0;
            end else begin
                case (mr_st)
                    0: if (mr_req_val) begin
                        if (mr_cnt >= req_delay) begin
                            mr_req_rdy = 1'b1;
                            {cap_n, cap_a, cap_b} = mr_req_msg;
                            mr_st = 1;
                        end else mr_cnt++;
                    end
                    1: begin
                        mr_req_rdy = 1'b0;
                        txn_cnt++;
                        mr_cnt = 0;
                        mr_st  = 2;
                    end
                    2: begin
                        if (mr_cnt >= resp_delay) begin
                            mr_resp_val = 1'b1;
                            mr_resp_msg = mulmod(cap_n, cap_a, cap_b);
                            mr_st = 3;
                        end else mr_cnt++;
                    end
                    default: begin
                        mr_resp_val = 1'b0;
                        mr_cnt = 0;
                        mr_st  = 0;
                    end
                endcase
            end
        end
    end

    // Protocol monitor: stability under backpressure and single-outstanding rule
    int viol_req = 0, viol_o = 0, viol_rdy = 0, viol_outst = 0;
    initial begin
        logic pv_req, pr_req, pv_o, pr_o;
        logic [W-1:0]  pm_req;
        logic [NB-1:0] pm_o;
        pv_req = 0; pr_req = 0; pv_o = 0; pr_o = 0; pm_req = '0; pm_o = '0;
        forever begin
            @(negedge clk); #1;
            if (!reset) begin
                pv_req = 0; pv_o = 0;
            end else begin
                if (pv_req && !pr_req && (!mr_req_val || mr_req_msg !== pm_req)) viol_req++;
                if (pv_o && !pr_o && (!ostream_val || ostream_msg !== pm_o)) viol_o++;
                if (busy && istream_rdy) viol_rdy++;
                if (mr_req_val && mr_resp_rdy) viol_outst++;
                pv_req = mr_req_val; pr_req = mr_req_rdy; pm_req = mr_req_msg;
                pv_o = ostream_val;  pr_o = ostream_rdy;  pm_o = ostream_msg;
            end
        end
    end

    task automatic start_job(input logic [NB-1:0] b, e, n, input string tag);
        int budget;
        @(negedge clk);
        istream_val = 1'b1;
        istream_msg = {n, e, b};
        budget = 200;
        while (!istream_rdy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!istream_rdy) check_eq({tag, "_accept_timeout"}, 0, 1);
        txn_cnt = 0;
        @(negedge clk);
        istream_val = 1'b0;
    endtask

    task automatic finish_job(input int ordy_dly, input logic [NB-1:0] exp_r,
                              input int exp_t, input string tag);
        int budget;
        budget = 20000;
        while (!ostream_val && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!ostream_val) begin
            check_eq({tag, "_done_timeout"}, 0, 1);
            return;
        end
        repeat (ordy_dly) @(negedge clk);
        ostream_rdy = 1'b1;
        check_eq({tag, "_result"}, 64'(ostream_msg), 64'(exp_r));
        check_eq({tag, "_txns"}, 64'(txn_cnt), 64'(exp_t));
        @(negedge clk);
        ostream_rdy = 1'b0;
    endtask

    task automatic run_job(input logic [NB-1:0] b, e, n, input int ordy_dly,
                           input logic [NB-1:0] exp_r, input int exp_t, input string tag);
        start_job(b, e, n, tag);
        finish_job(ordy_dly, exp_r, exp_t, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] b, e, n;
        int budget;
        logic found;

        reset = 1'b1; istream_val = 1'b0; istream_msg = '0; ostream_rdy = 1'b0;
        #1 reset = 1'b0;
        #10;
        check_eq("rst_istream_rdy", 64'(istream_rdy), 0);
        check_eq("rst_ostream_val", 64'(ostream_val), 0);
        check_eq("rst_mr_req_val",  64'(mr_req_val), 0);
        check_eq("rst_mr_resp_rdy", 64'(mr_resp_rdy), 0);
        check_eq("rst_busy",        64'(busy), 0);
        check_eq("rst_ostream_msg", 64'(ostream_msg), 0);
        @(negedge clk);
        reset = 1'b1;
        #1 check_eq("rdy_after_reset", 64'(istream_rdy), 1);

        // Directed cases with known answers
        run_job(32'd4,   32'd13, 32'd497, 0, 32'd445, 8, "b4e13n497");
        run_job(32'd7,   32'd0,  32'd10,  1, 32'd1,   2, "b7e0n10");
        run_job(32'd5,   32'd3,  32'd1,   0, 32'd0,   5, "b5e3n1");
        run_job(32'd100, 32'd2,  32'd7,   2, 32'd4,   4, "b100e2n7");

        // Heavy backpressure on every handshake
        req_delay = 5; resp_delay = 7;
        run_job(32'd123456789, 32'd65537, 32'd1000000007, 10,
                ref_modexp(32'd123456789, 32'd65537, 32'd1000000007),
                ref_txns(32'd65537), "stall");

        // Reset pulse during a squaring wait
        req_delay = 1; resp_delay = 4;
        start_job(32'd4, 32'd13, 32'd497, "rstmid");
        found = 1'b0;
        budget = 2000;
        while (!found && budget > 0) begin
            @(negedge clk); #1;
            if (mr_resp_rdy && cap_a == cap_b && cap_b != 32'd1) found = 1'b1;
            budget--;
        end
        check_eq("rstmid_found_sqr_wait", 64'(found), 1);
        #1 reset = 1'b0;
        #1;
        check_eq("rstmid_istream_rdy", 64'(istream_rdy), 0);
        check_eq("rstmid_ostream_val", 64'(ostream_val), 0);
        check_eq("rstmid_mr_req_val",  64'(mr_req_val), 0);
        check_eq("rstmid_mr_resp_rdy", 64'(mr_resp_rdy), 0);
        check_eq("rstmid_busy",        64'(busy), 0);
        check_eq("rstmid_ostream_msg", 64'(ostream_msg), 0);
        check_eq("rstmid_mr_req_msg",  64'(mr_req_msg), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req_delay = 0; resp_delay = 0;
        run_job(32'd3, 32'd5, 32'd7, 0, 32'd5, 6, "after_rst");

        // Back-to-back with istream_val held high
        @(negedge clk);
        istream_val = 1'b1;
        istream_msg = {32'd497, 32'd13, 32'd4};
        budget = 200;
        while (!istream_rdy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        txn_cnt = 0;
        @(negedge clk);
        istream_msg = {32'd7, 32'd5, 32'd3};
        budget = 20000;
        while (!ostream_val && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        ostream_rdy = 1'b1;
        check_eq("b2b1_result", 64'(ostream_msg), 445);
        check_eq("b2b1_txns", 64'(txn_cnt), 8);
        @(negedge clk);
        ostream_rdy = 1'b0;
        check_eq("b2b_rdy_next_cycle", 64'(istream_rdy), 1);
        txn_cnt = 0;
        @(negedge clk);
        istream_val = 1'b0;
        check_eq("b2b_accepted", 64'(busy), 1);
        finish_job(0, 32'd5, 6, "b2b2");

        // Randomized jobs against the arithmetic reference
        for (int k = 0; k < 20; k++) begin
            req_delay  = $urandom_range(0, 3);
            resp_delay = $urandom_range(0, 3);
            b = $urandom;
            e = ($urandom_range(0, 3) == 0) ? NB'($urandom_range(0, 15)) : NB'($urandom);
            n = ($urandom_range(0, 3) == 0) ? NB'($urandom_range(1, 1000)) : NB'($urandom);
            if (n == '0) n = 32'd1;
            run_job(b, e, n, $urandom_range(0, 3), ref_modexp(b, e, n), ref_txns(e), "rand");
        end

        check_eq("req_msg_stable",      64'(viol_req), 0);
        check_eq("ostream_msg_stable",  64'(viol_o), 0);
        check_eq("istream_rdy_busy",    64'(viol_rdy), 0);
        check_eq("single_outstanding",  64'(viol_outst), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rsa_xcel_naive_modexp_ctrl.md
RSA_XCEL_NAIVE_MODEXP_CTRL -- requirements
Module: rsa_xcel_naive_modexp_ctrl

Interface
REQ-001 SHALL have parameter: nbits, 32, operand width of base, exponent, modulus and result.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port: istream_msg  input  3*nbits  {n, e, base}; n in [3*nbits-1:2*nbits], e in [2*nbits-1:nbits], base in [nbits-1:0].
REQ-005 SHALL have ports: istream_val input 1, istream_rdy output 1; request handshake.
REQ-006 SHALL have port: ostream_msg  output  nbits  result base^e mod n.
REQ-007 SHALL have ports: ostream_val output 1, ostream_rdy input 1; response handshake.
REQ-008 SHALL have port: mr_req_msg  output  3*nbits  {n, opa, opb} to the multiply-remainder unit.
REQ-009 SHALL have ports: mr_req_val output 1, mr_req_rdy input 1; request handshake to the multiply-remainder unit.
REQ-010 SHALL have port: mr_resp_msg  input  nbits  (opa*opb) mod n from the multiply-remainder unit.
REQ-011 SHALL have ports: mr_resp_val input 1, mr_resp_rdy output 1; response handshake from the multiply-remainder unit.
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL accept one job per transfer (istream_val & istream_rdy); istream_rdy = 1 only in IDLE.
REQ-014 SHALL latch n, e and base into internal registers N, E and B on accept; R (accumulator) is internal.
REQ-015 SHALL implement FSM states IDLE, RED_B, RED_R, CHECK, MUL, SQR, DONE; MUL, SQR, RED_B and RED_R each have REQ and WAIT sub-phases.
REQ-016 SHALL use the following per-state operation, each a single multiply-remainder transaction: RED_B issues {N, B, 1} and sets B = resp; RED_R issues {N, 1, 1} and sets R = resp (1 mod n); MUL issues {N, R, B} and sets R = resp; SQR issues {N, B, B} and sets B = resp.
REQ-017 SHALL use the following transitions: IDLE -> RED_B on accept; RED_B -> RED_R; RED_R -> CHECK.
REQ-018 SHALL decide in CHECK: if E == 0 go to DONE; else if E[0] go to MUL; else go to SQR.
REQ-019 SHALL leave MUL as follows: if E[nbits-1:1] == 0, shift E right by 1 and go to DONE (final squaring skipped); else go to SQR.
REQ-020 SHALL leave SQR by shifting E right by 1 and returning to CHECK.
REQ-021 SHALL, in REQ phase, drive mr_req_val = 1 with mr_req_msg stable until mr_req_rdy; it SHALL move to WAIT on the handshake cycle.
REQ-022 SHALL assert mr_resp_rdy = 1 only in WAIT phases; it SHALL capture mr_resp_msg and advance on mr_resp_val & mr_resp_rdy.
REQ-023 SHALL keep at most one multiply-remainder transaction outstanding, and no request SHALL issue while in a WAIT phase.
REQ-024 SHALL drive ostream_val = 1 and ostream_msg = R in DONE, holding both stable until ostream_rdy; it SHALL return to IDLE on the handshake cycle.
REQ-025 SHALL drive mr_req_val, mr_resp_rdy and ostream_val to 0 outside their states.
REQ-026 SHALL produce exactly 2 + popcount(e) + (bit position of MSB of e) transactions per job (2 when e == 0).
REQ-027 SHALL NOT check for n == 0; the controller SHALL still complete and return R as supplied by the unit.
REQ-028 SHALL ignore mr_resp_val outside WAIT phases and istream_val outside IDLE.

Reset
REQ-029 SHALL, while reset == 0, immediately force state IDLE and N, E, B, R to 0 without waiting for a clock edge.
REQ-030 SHALL, during reset, drive istream_rdy = 0, ostream_val = 0, mr_req_val = 0, mr_resp_rdy = 0, busy = 0, ostream_msg = 0.
REQ-031 SHALL abandon any in-flight job when reset asserts mid-operation; the multiply-remainder unit shares the same reset; the first accept is possible in the first cycle after deassertion.

Verification
REQ-032 SHALL cover: base = 4, e = 13, n = 497 -> ostream_msg = 445, 8 multiply-remainder transactions.
REQ-033 SHALL cover: base = 7, e = 0, n = 10 -> result 1, 2 transactions; and base = 5, e = 3, n = 1 -> result 0.
REQ-034 SHALL cover: base = 100, e = 2, n = 7 -> result 4, 4 transactions (base reduction exercised).
REQ-035 SHALL cover: mr_req_rdy low 5 cycles, mr_resp_val delayed 7 cycles, ostream_rdy low 10 cycles -> mr_req_msg and ostream_msg stable while val high, istream_rdy = 0 throughout, correct result.
REQ-036 SHALL cover: reset pulsed low during SQR WAIT -> all outputs 0 asynchronously, busy = 0, next job 3^5 mod 7 -> 5.
REQ-037 SHALL cover: back-to-back jobs with istream_val held high -> second job accepted in the cycle after the first ostream handshake; both results correct.
